// File: rtl/bq_out_fifo.sv
// Capture FIFO behind the biquad core: first-word-fall-through sample buffer
// with a sticky overflow flag and a peak-magnitude tracker.
module bq_out_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          bq_clk_i,
  input  logic          nreset,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  input  logic          pop_i,
  input  logic          clr_i,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o,
  output logic [DW-1:0] peak_o
);

  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   LVL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] NEG_MIN   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] POS_MAX   = {1'b0, {(DW-1){1'b1}}};

  // Magnitude of a two's complement sample, most-negative value saturated.
  function automatic logic [DW-1:0] sat_abs(input logic [DW-1:0] x);
    logic [DW-1:0] r;
    if (!x[DW-1]) begin
      r = x;
    end else if (x == NEG_MIN) begin
      r = POS_MAX;
    end else begin
      r = ~x + {{(DW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [DW-1:0] head_q, head_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] peak_q, peak_d;
  logic          ready_q;
  logic          pop_acc_s, push_acc_s, drop_s;
  logic [DW-1:0] abs_s;

  // Handshake decode, pointer/level update and registered FWFT head selection.
  always_comb begin
    pop_acc_s  = ready_q & pop_i & ~empty_q;
    push_acc_s = ready_q & in_valid_i & (~full_q | pop_acc_s);
    drop_s     = ready_q & in_valid_i & full_q & ~pop_acc_s;
    abs_s      = sat_abs(in_data_i);

    wr_ptr_d = push_acc_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_acc_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_acc_s, pop_acc_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LVL_FULL);
    empty_d = (level_d == LVL_ZERO);

    // Slot under the new read pointer is being written only when the FIFO
    // would otherwise be empty, so forward the incoming sample in that case.
    if (empty_d) begin
      head_d = DATA_ZERO;
    end else if (push_acc_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = in_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (clr_i) begin
      peak_d = push_acc_s ? abs_s : DATA_ZERO;
    end else if (push_acc_s && (abs_s > peak_q)) begin
      peak_d = abs_s;
    end else begin
      peak_d = peak_q;
    end
  end

  // Sample storage; deliberately not reset.
  always_ff @(posedge bq_clk_i) begin
    if (push_acc_s) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // Control and status registers; ready_q blocks transfers on the first edge after release.
  always_ff @(posedge bq_clk_i or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= LVL_ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      head_q   <= DATA_ZERO;
      ovf_q    <= 1'b0;
      peak_q   <= DATA_ZERO;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
      peak_q   <= peak_d;
      ready_q  <= 1'b1;
    end
  end

  assign out_valid_o = ~empty_q;
  assign out_data_o  = head_q;
  assign level_o     = level_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign overflow_o  = ovf_q;
  assign peak_o      = peak_q;

endmodule

// File: tb/tb_bq_out_fifo.sv
// Self-checking bench for bq_out_fifo: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_bq_out_fifo;

  logic        clk = 1'b0;
  logic        nreset;
  logic        in_valid, pop, clr;
  logic [15:0] in_data;
  logic        out_valid, full, empty, overflow;
  logic [15:0] out_data, peak;
  logic [4:0]  level;

  int tests = 0;
  int fails = 0;

  logic [15:0] mq[$];
  logic        m_ov;
  logic [15:0] m_peak;
  bit          m_ready;
  bit          cmp_en;

  always #5 clk = ~clk;

  bq_out_fifo #(.DW(16), .DEPTH(16), .AW(4)) dut (
    .bq_clk_i(clk), .nreset(nreset), .in_valid_i(in_valid), .in_data_i(in_data),
    .pop_i(pop), .clr_i(clr), .out_valid_o(out_valid), .out_data_o(out_data),
    .level_o(level), .full_o(full), .empty_o(empty), .overflow_o(overflow),
    .peak_o(peak)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mag(input logic [15:0] x);
    int s;
    s = int'($signed(x));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return 16'(s);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ov = 1'b0;
    m_peak = 16'h0000;
    m_ready = 1'b0;
  endtask

  // Reference behaviour at one rising edge, using the inputs as driven.
  task automatic model_edge();
    bit pa, wa, dr;
    if (!nreset) begin
      m_ready = 1'b0;
    end else begin
      pa = 1'b0; wa = 1'b0; dr = 1'b0;
      if (m_ready) begin
        pa = pop && (mq.size() > 0);
        wa = in_valid && ((mq.size() < 16) || pa);
        dr = in_valid && !wa;
      end
      if (pa) void'(mq.pop_front());
      if (wa) mq.push_back(in_data);
      if (clr) begin
        m_ov = 1'b0;
        m_peak = 16'h0000;
      end
      if (dr) m_ov = 1'b1;
      if (wa && (mag(in_data) > m_peak)) m_peak = mag(in_data);
      m_ready = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_data", 32'(out_data), 32'((mq.size() != 0) ? mq[0] : 16'h0000));
      chk("level", 32'(level), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == 16));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("peak", 32'(peak), 32'(m_peak));
    end
  end

  task automatic cyc(input bit v, input logic [15:0] d, input bit p, input bit c);
    in_valid = v; in_data = d; pop = p; clr = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    in_valid = 1'b0; in_data = 16'h0000; pop = 1'b0; clr = 1'b0;
    nreset = 1'b1;
    model_reset();
    #1 nreset = 1'b0;
    #1 cmp_en = 1'b1;
    @(negedge clk);

    // Reset held with input activity
    for (int i = 0; i < 4; i++) cyc(i[0], 16'hAAAA, 1'b0, 1'b0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_peak", 32'(peak), 32'd0);
    nreset = 1'b1;
    cyc(1'b1, 16'h7777, 1'b0, 1'b0);
    chk("first_edge_no_push", 32'(level), 32'd0);

    // Fill and drain
    for (int i = 1; i <= 16; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", 32'(out_data), 32'(i));
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Overflow
    for (int i = 0; i < 16; i++) cyc(1'b1, 16'h0020 + 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("drop_ovf", 32'(overflow), 32'd1);
    chk("drop_level", 32'(level), 32'd16);
    cyc(1'b1, 16'h4321, 1'b1, 1'b0);
    chk("pushpop_full_level", 32'(level), 32'd16);
    chk("pushpop_full_ovf", 32'(overflow), 32'd1);
    chk("pushpop_head", 32'(out_data), 32'h0021);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_peak", 32'(peak), 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Peak tracking and clear-with-push
    cyc(1'b1, 16'h0100, 1'b0, 1'b0);
    chk("peak_pos", 32'(peak), 32'h0100);
    cyc(1'b1, 16'hFF00, 1'b0, 1'b0);
    chk("peak_neg", 32'(peak), 32'h0100);
    cyc(1'b1, 16'h8000, 1'b0, 1'b0);
    chk("peak_sat", 32'(peak), 32'h7FFF);
    for (int i = 0; i < 13; i++) cyc(1'b1, 16'h0001, 1'b0, 1'b0);
    cyc(1'b1, 16'h0002, 1'b0, 1'b0);
    chk("peak_drop_ovf", 32'(overflow), 32'd1);
    chk("peak_drop_keep", 32'(peak), 32'h7FFF);
    cyc(1'b1, 16'h0005, 1'b1, 1'b1);
    chk("clr_push_peak", 32'(peak), 32'h0005);
    chk("clr_push_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // FWFT on empty, pop while empty
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("fwft_valid", 32'(out_valid), 32'd1);
    chk("fwft_data", 32'(out_data), 32'hBEEF);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("pop_empty_level", 32'(level), 32'd0);
    chk("pop_empty_data", 32'(out_data), 32'd0);

    // Random traffic with wrap, async reset mid-stream
    for (int n = 0; n < 160; n++) begin
      if (n == 80) begin
        #2 nreset = 1'b0;
        model_reset();
        #1;
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_data", 32'(out_data), 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        chk("async_rst_peak", 32'(peak), 32'd0);
        cyc(1'b1, 16'h1111, 1'b1, 1'b0);
        nreset = 1'b1;
      end
      cyc($urandom_range(0, 99) < 70, 16'($urandom), $urandom_range(0, 99) < 55,
          $urandom_range(0, 99) < 4);
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
